// File: rtl/sim_run_sequencer.sv
// sim_run_sequencer
// Scripted front-panel operator used in simulation. It takes one run command,
// then drives the soc_top panel in a fixed order: clear PU, arrange STRT
// (and check it reads back), optionally arrange SEL and C, optionally load
// the tape via the input device, then start execution. It then watches the
// PU until it has been stopped and quiet for IDLE_HOLD consecutive cycles.
// At the end it reports a status code and the cycle count of the run.
//
// Ports
//   clk, resetn          clock; asynchronous active-low reset
//   cmd_val / cmd_rdy    command handshake (see below)
//   cmd_strt, cmd_sel    STRT / SEL values to arrange
//   cmd_c                register C value to arrange
//   cmd_flags            [0] arrange SEL, [1] arrange C, [2] tape load
//   pnl_pu_state         PU state from soc_top, 3'o0 = stopped
//   pnl_input_active     input device busy
//   pnl_output_active    output device busy
//   pnl_strt_value       STRT readback
//   btn_*                one-cycle button pulses to the panel
//   pnl_do_arr_*         one-cycle arrange strobes to the panel
//   pnl_arr_*_value      arrange data, held from the last accepted command
//   done                 one-cycle pulse at the end of a sequence
//   status               0 OK, 1 TIMEOUT, 2 STRT_MISMATCH, 3 NO_START
//   run_cycles           cycles spent in RUN_WAIT, saturating
//   dbg_state            current FSM state encoding
//
// Handshake: a command transfers on a rising clk edge where cmd_val and
// cmd_rdy are both 1. cmd_rdy is 1 only while idle; cmd_val while busy is
// dropped, not queued. The sender may change cmd_* freely after transfer.
module sim_run_sequencer #(
  parameter int unsigned IDLE_HOLD = 255,
  parameter int unsigned TIMEOUT   = 1048576,
  parameter int unsigned START_WIN = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_val,
  output logic        cmd_rdy,
  input  logic [11:0] cmd_strt,
  input  logic [11:0] cmd_sel,
  input  logic [30:0] cmd_c,
  input  logic [2:0]  cmd_flags,
  input  logic [2:0]  pnl_pu_state,
  input  logic        pnl_input_active,
  input  logic        pnl_output_active,
  input  logic [11:0] pnl_strt_value,
  output logic        btn_clear_pu,
  output logic        btn_start_input,
  output logic        btn_start_pulse,
  output logic        pnl_do_arr_strt,
  output logic        pnl_do_arr_sel,
  output logic        pnl_do_arr_c,
  output logic [11:0] pnl_arr_strt_value,
  output logic [11:0] pnl_arr_sel_value,
  output logic [30:0] pnl_arr_reg_c_value,
  output logic        done,
  output logic [1:0]  status,
  output logic [31:0] run_cycles,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_ARR_STRT, S_CHK_STRT, S_ARR_SEL, S_ARR_C,
    S_LOAD_GO, S_LOAD_WAIT, S_RUN_GO, S_RUN_WAIT, S_DONE
  } state_t;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_TIMEOUT  = 2'd1;
  localparam logic [1:0] ST_MISMATCH = 2'd2;
  localparam logic [1:0] ST_NO_START = 2'd3;

  state_t      state, state_nxt;
  logic [1:0]  fin_status;
  logic [2:0]  flags_q;
  // win_cnt counts cycles since the go pulse (set to 1 on the pulse cycle),
  // so the no-start abort lands exactly START_WIN cycles after the pulse.
  logic [31:0] win_cnt;
  logic [31:0] tmo_cnt;
  logic [31:0] quiet_cnt;
  logic        started;
  logic        quiet;

  assign dbg_state = state;
  assign quiet = (pnl_pu_state == 3'o0) && !pnl_input_active && !pnl_output_active;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Optional states are chained; each helper skips the ones not requested.
  function automatic state_t after_c(input logic [2:0] f);
    return f[2] ? S_LOAD_GO : S_RUN_GO;
  endfunction
  function automatic state_t after_sel(input logic [2:0] f);
    return f[1] ? S_ARR_C : after_c(f);
  endfunction
  function automatic state_t after_chk(input logic [2:0] f);
    return f[0] ? S_ARR_SEL : after_sel(f);
  endfunction

  always_comb begin
    state_nxt  = state;
    fin_status = ST_OK;
    case (state)
      S_IDLE:     if (cmd_val && cmd_rdy) state_nxt = S_CLEAR;
      S_CLEAR:    state_nxt = S_ARR_STRT;
      S_ARR_STRT: state_nxt = S_CHK_STRT;
      S_CHK_STRT: begin
        // Second cycle in this state: readback has had two cycles to settle.
        if (win_cnt == 32'd1) begin
          if (pnl_strt_value != pnl_arr_strt_value) begin
            state_nxt  = S_DONE;
            fin_status = ST_MISMATCH;
          end else begin
            state_nxt = after_chk(flags_q);
          end
        end
      end
      S_ARR_SEL:  state_nxt = after_sel(flags_q);
      S_ARR_C:    state_nxt = after_c(flags_q);
      S_LOAD_GO:  state_nxt = S_LOAD_WAIT;
      S_LOAD_WAIT: begin
        if (!started && !pnl_input_active && win_cnt >= START_WIN - 1) begin
          state_nxt  = S_DONE;
          fin_status = ST_NO_START;
        end else if (started && !pnl_input_active) begin
          state_nxt = S_RUN_GO;
        end else if (tmo_cnt >= TIMEOUT - 1) begin
          state_nxt  = S_DONE;
          fin_status = ST_TIMEOUT;
        end
      end
      S_RUN_GO:   state_nxt = S_RUN_WAIT;
      S_RUN_WAIT: begin
        if (!started && pnl_pu_state == 3'o0 && win_cnt >= START_WIN - 1) begin
          state_nxt  = S_DONE;
          fin_status = ST_NO_START;
        end else if (started && quiet && quiet_cnt >= IDLE_HOLD - 1) begin
          state_nxt  = S_DONE;
          fin_status = ST_OK;
        end else if (tmo_cnt >= TIMEOUT - 1) begin
          state_nxt  = S_DONE;
          fin_status = ST_TIMEOUT;
        end
      end
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state               <= S_IDLE;
      cmd_rdy             <= 1'b1;
      btn_clear_pu        <= 1'b0;
      btn_start_input     <= 1'b0;
      btn_start_pulse     <= 1'b0;
      pnl_do_arr_strt     <= 1'b0;
      pnl_do_arr_sel      <= 1'b0;
      pnl_do_arr_c        <= 1'b0;
      pnl_arr_strt_value  <= '0;
      pnl_arr_sel_value   <= '0;
      pnl_arr_reg_c_value <= '0;
      flags_q             <= '0;
      done                <= 1'b0;
      status              <= ST_OK;
      run_cycles          <= '0;
      win_cnt             <= '0;
      tmo_cnt             <= '0;
      quiet_cnt           <= '0;
      started             <= 1'b0;
    end else begin
      state <= state_nxt;
      // Every pulse state lasts exactly one cycle, so registering "next state
      // is X" gives a clean single-cycle pulse aligned with that state.
      cmd_rdy         <= (state_nxt == S_IDLE);
      btn_clear_pu    <= (state_nxt == S_CLEAR);
      pnl_do_arr_strt <= (state_nxt == S_ARR_STRT);
      pnl_do_arr_sel  <= (state_nxt == S_ARR_SEL);
      pnl_do_arr_c    <= (state_nxt == S_ARR_C);
      btn_start_input <= (state_nxt == S_LOAD_GO);
      btn_start_pulse <= (state_nxt == S_RUN_GO);
      done            <= (state_nxt == S_DONE);
      if (state_nxt == S_DONE) status <= fin_status;

      case (state)
        S_IDLE: begin
          if (cmd_val && cmd_rdy) begin
            pnl_arr_strt_value  <= cmd_strt;
            pnl_arr_sel_value   <= cmd_sel;
            pnl_arr_reg_c_value <= cmd_c;
            flags_q             <= cmd_flags;
            status              <= ST_OK;
            run_cycles          <= '0;
            win_cnt             <= '0;
            tmo_cnt             <= '0;
            quiet_cnt           <= '0;
            started             <= 1'b0;
          end
        end
        S_CHK_STRT: win_cnt <= sat_inc(win_cnt);
        S_LOAD_GO, S_RUN_GO: begin
          win_cnt   <= 32'd1;
          tmo_cnt   <= '0;
          quiet_cnt <= '0;
          started   <= 1'b0;
        end
        S_LOAD_WAIT: begin
          tmo_cnt <= sat_inc(tmo_cnt);
          if (!started) begin
            if (pnl_input_active) started <= 1'b1;
            else                  win_cnt <= sat_inc(win_cnt);
          end
        end
        S_RUN_WAIT: begin
          tmo_cnt    <= sat_inc(tmo_cnt);
          run_cycles <= sat_inc(run_cycles);
          if (!started) begin
            if (pnl_pu_state != 3'o0) started <= 1'b1;
            else                      win_cnt <= sat_inc(win_cnt);
          end else if (quiet) begin
            quiet_cnt <= sat_inc(quiet_cnt);
          end else begin
            // Any single busy cycle restarts the stop window.
            quiet_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
